// File: rtl/core_axi_burst_bridge_pkg.sv
// Shared definitions for the Avalon-MM to AXI4 burst bridge: AXI/Avalon codes,
// FSM state type and the AXI-to-Avalon response mapping.
package core_bus_pkg;

  localparam int unsigned AXI_LEN_W = 8;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AV_RESP_OK     = 2'b00;
  localparam logic [1:0] AV_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AV_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RD_PAD
  } bridge_state_e;

  function automatic logic [1:0] resp_map(input logic [1:0] axi_resp);
    logic [1:0] av_resp;
    case (axi_resp)
      AXI_RESP_OKAY, AXI_RESP_EXOKAY: av_resp = AV_RESP_OK;
      AXI_RESP_SLVERR:                av_resp = AV_RESP_SLVERR;
      default:                        av_resp = AV_RESP_DECERR;
    endcase
    return av_resp;
  endfunction

endpackage

// File: rtl/core_axi_burst_bridge_if.sv
// Bus bundles for the bridge: the Avalon-MM burst port and the AXI4 port,
// each with master/slave modports.
interface core_avalon_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BCNT_W = 8
);
  logic [ADDR_W-1:0]   addr;
  logic [BCNT_W-1:0]   burstcount;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                writeresponsevalid;
  logic [1:0]          response;

  modport master (
    output addr, burstcount, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid, writeresponsevalid, response
  );
  modport slave (
    input  addr, burstcount, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid, writeresponsevalid, response
  );
endinterface

interface core_axi_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/core_axi_burst_bridge.sv
// Avalon-MM burst slave to AXI4 master bridge; one transaction in flight,
// each Avalon burst becomes a single AXI INCR burst.
module core_axi_burst_bridge
  import core_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned AXI_ID = 0,
  parameter int unsigned BCNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  core_avalon_if.slave  slv_bus,
  core_axi_if.master    mst_axi,
  output logic          err_proto,
  input  logic          err_clr
);

  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_W / 8));

  bridge_state_e          state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [AXI_LEN_W-1:0]   len_q, len_d;
  logic [AXI_LEN_W-1:0]   cnt_q, cnt_d;
  logic                   awvalid_q, awvalid_d;
  logic                   arvalid_q, arvalid_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic                   rdv_q, rdv_d;
  logic                   wrv_q, wrv_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [1:0]             resp_q, resp_d;
  logic                   err_q, err_d;

  logic                   wait_c, wvalid_c, wlast_c, bready_c, rready_c;
  logic                   aw_hs, w_beat, err_set;
  logic [BCNT_W-1:0]      bcnt_m1;
  logic [AXI_LEN_W-1:0]   cmd_len;
  logic                   unused_ids;

  // burstcount 0 is treated as a single beat
  assign bcnt_m1 = (slv_bus.burstcount == '0) ? '0 : slv_bus.burstcount - BCNT_W'(1);
  assign cmd_len = AXI_LEN_W'(bcnt_m1);
  assign aw_hs   = awvalid_q && mst_axi.awready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    awvalid_d = awvalid_q;
    arvalid_d = arvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdv_d     = 1'b0;
    wrv_d     = 1'b0;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    err_set   = 1'b0;
    wait_c    = 1'b1;
    wvalid_c  = 1'b0;
    wlast_c   = 1'b0;
    bready_c  = 1'b0;
    rready_c  = 1'b0;
    w_beat    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // stray R beats left over from a short burst are swallowed here
        rready_c = 1'b1;
        if (slv_bus.write) begin
          addr_d    = slv_bus.addr;
          len_d     = cmd_len;
          cnt_d     = '0;
          awvalid_d = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR;
        end else if (slv_bus.read) begin
          wait_c    = 1'b0;
          addr_d    = slv_bus.addr;
          len_d     = cmd_len;
          cnt_d     = '0;
          arvalid_d = 1'b1;
          state_d   = S_RD_ADDR;
        end
      end
      S_WR: begin
        wvalid_c = slv_bus.write && !w_done_q;
        wlast_c  = (cnt_q == len_q);
        wait_c   = !mst_axi.wready || w_done_q;
        w_beat   = wvalid_c && mst_axi.wready;
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_beat) begin
          if (wlast_c) w_done_d = 1'b1;
          else         cnt_d    = cnt_q + AXI_LEN_W'(1);
        end
        if ((aw_done_q || aw_hs) && (w_done_q || (w_beat && wlast_c))) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        bready_c = 1'b1;
        if (mst_axi.bvalid) begin
          wrv_d   = 1'b1;
          resp_d  = resp_map(mst_axi.bresp);
          state_d = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (mst_axi.arready) begin
          arvalid_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        rready_c = 1'b1;
        if (mst_axi.rvalid) begin
          rdv_d   = 1'b1;
          rdata_d = mst_axi.rdata;
          resp_d  = resp_map(mst_axi.rresp);
          cnt_d   = cnt_q + AXI_LEN_W'(1);
          if (mst_axi.rlast) begin
            if (cnt_q != len_q) begin
              err_set = 1'b1;
              state_d = S_RD_PAD;
            end else begin
              state_d = S_IDLE;
            end
          end else if (cnt_q == len_q) begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_RD_PAD: begin
        rdv_d   = 1'b1;
        rdata_d = '0;
        resp_d  = AV_RESP_DECERR;
        cnt_d   = cnt_q + AXI_LEN_W'(1);
        if (cnt_q == len_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdv_q     <= 1'b0;
      wrv_q     <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= AV_RESP_OK;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      awvalid_q <= awvalid_d;
      arvalid_q <= arvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdv_q     <= rdv_d;
      wrv_q     <= wrv_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
    end
  end

  assign mst_axi.awid    = ID_W'(AXI_ID);
  assign mst_axi.awaddr  = addr_q;
  assign mst_axi.awlen   = len_q;
  assign mst_axi.awsize  = AXSIZE;
  assign mst_axi.awburst = AXI_BURST_INCR;
  assign mst_axi.awlock  = 1'b0;
  assign mst_axi.awcache = '0;
  assign mst_axi.awprot  = '0;
  assign mst_axi.awqos   = '0;
  assign mst_axi.awvalid = awvalid_q;
  assign mst_axi.wdata   = slv_bus.writedata;
  assign mst_axi.wstrb   = slv_bus.byteenable;
  assign mst_axi.wlast   = wlast_c;
  assign mst_axi.wvalid  = wvalid_c;
  assign mst_axi.bready  = bready_c;
  assign mst_axi.arid    = ID_W'(AXI_ID);
  assign mst_axi.araddr  = addr_q;
  assign mst_axi.arlen   = len_q;
  assign mst_axi.arsize  = AXSIZE;
  assign mst_axi.arburst = AXI_BURST_INCR;
  assign mst_axi.arlock  = 1'b0;
  assign mst_axi.arcache = '0;
  assign mst_axi.arprot  = '0;
  assign mst_axi.arqos   = '0;
  assign mst_axi.arvalid = arvalid_q;
  assign mst_axi.rready  = rready_c;

  assign slv_bus.waitrequest        = wait_c;
  assign slv_bus.readdata           = rdata_q;
  assign slv_bus.readdatavalid      = rdv_q;
  assign slv_bus.writeresponsevalid = wrv_q;
  assign slv_bus.response           = resp_q;
  assign err_proto                  = err_q;

  assign unused_ids = ^{mst_axi.bid, mst_axi.rid};

endmodule

// File: tb/tb_core_axi_burst_bridge.sv
// Randomized self-checking bench for core_axi_burst_bridge; Avalon master and
// AXI slave are modelled per transaction with expected beats kept in queues.
module tb_core_axi_burst_bridge;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned BCNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_proto;
  logic err_clr = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  // AXI response -> Avalon response, indexed by the AXI code
  logic [1:0] map_tab [4] = '{2'b00, 2'b00, 2'b10, 2'b11};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  core_avalon_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BCNT_W(BCNT_W)) av();
  core_axi_if    #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W))     ax();

  core_axi_burst_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .AXI_ID(0), .BCNT_W(BCNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .slv_bus(av), .mst_axi(ax),
    .err_proto(err_proto), .err_clr(err_clr)
  );

  task automatic idle_inputs();
    av.addr = '0; av.burstcount = '0; av.read = 0; av.write = 0;
    av.writedata = '0; av.byteenable = '0;
    ax.awready = 0; ax.wready = 0; ax.bid = '0; ax.bresp = '0; ax.bvalid = 0;
    ax.arready = 0; ax.rid = '0; ax.rdata = '0; ax.rresp = '0; ax.rlast = 0; ax.rvalid = 0;
  endtask

  task automatic check_quiet(input string nm);
    n_vec++; if ({ax.awvalid, ax.wvalid, ax.arvalid} !== 3'b000) begin n_err++; $display("FAIL %s axi valids: got %b want 000", nm, {ax.awvalid, ax.wvalid, ax.arvalid}); end
    n_vec++; if ({av.readdatavalid, av.writeresponsevalid, err_proto} !== 3'b000) begin n_err++; $display("FAIL %s rdv/wrv/err: got %b want 000", nm, {av.readdatavalid, av.writeresponsevalid, err_proto}); end
    n_vec++; if (av.waitrequest !== 1'b1) begin n_err++; $display("FAIL %s waitrequest: got %b want 1", nm, av.waitrequest); end
    n_vec++; if (av.readdata !== '0) begin n_err++; $display("FAIL %s readdata: got %h want 0", nm, av.readdata); end
    n_vec++; if (av.response !== 2'b00) begin n_err++; $display("FAIL %s response: got %b want 00", nm, av.response); end
  endtask

  task automatic do_write(input logic [31:0] addr, input int bc, input int aw_delay, input int wmode,
                          input logic [1:0] bresp, input bit also_read, input bit use_first,
                          input logic [31:0] first_data, input string nm);
    int eff, av_idx, w_idx, aw_cnt, aw_wait, b_hs_cyc, wrv_cnt, bdelay;
    bit w_last_done;
    logic [31:0] dat[$];
    logic [3:0]  be[$];
    eff = (bc == 0) ? 1 : bc;
    av_idx = 0; w_idx = 0; aw_cnt = 0; aw_wait = 0; b_hs_cyc = -1; wrv_cnt = 0; w_last_done = 0;
    bdelay = $urandom_range(0, 2);
    for (int i = 0; i < eff; i++) begin
      dat.push_back((i == 0 && use_first) ? first_data : $urandom);
      be.push_back(4'($urandom_range(1, 15)));
    end
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      av.read = also_read && (c == 0);
      if (av_idx < eff) begin
        av.write = 1; av.addr = addr; av.burstcount = BCNT_W'(bc);
        av.writedata = dat[av_idx]; av.byteenable = be[av_idx];
      end else av.write = 0;
      ax.awready = (aw_wait >= aw_delay);
      ax.wready = (wmode == 0) ? 1'b1 : (wmode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      ax.bresp = bresp;
      if (b_hs_cyc >= 0) ax.bvalid = 0;
      else if (aw_cnt > 0 && w_last_done) begin
        if (bdelay == 0) ax.bvalid = 1; else bdelay--;
      end
      #1;
      if (also_read && c == 0) begin
        n_vec++; if (av.waitrequest !== 1'b1) begin n_err++; $display("FAIL %s rd+wr waitrequest: got %b want 1", nm, av.waitrequest); end
      end
      if (also_read && c == 1) begin
        n_vec++; if ({ax.awvalid, ax.arvalid} !== 2'b10) begin n_err++; $display("FAIL %s priority aw/ar valid: got %b want 10", nm, {ax.awvalid, ax.arvalid}); end
      end
      if (ax.awvalid) aw_wait++;
      if (ax.awvalid && ax.awready) begin
        aw_cnt++;
        n_vec++; if (ax.awaddr !== addr) begin n_err++; $display("FAIL %s awaddr: got %h want %h", nm, ax.awaddr, addr); end
        n_vec++; if (ax.awlen !== 8'(eff - 1)) begin n_err++; $display("FAIL %s awlen: got %0d want %0d", nm, ax.awlen, eff - 1); end
        n_vec++; if ({ax.awsize, ax.awburst, ax.awid} !== {3'd2, 2'b01, 4'd0}) begin n_err++; $display("FAIL %s aw size/burst/id: got %b/%b/%0d want 010/01/0", nm, ax.awsize, ax.awburst, ax.awid); end
        n_vec++; if ({ax.awlock, ax.awcache, ax.awprot, ax.awqos} !== 12'h0) begin n_err++; $display("FAIL %s aw lock/cache/prot/qos: got nonzero want 0", nm); end
      end
      if (ax.wvalid && ax.wready) begin
        if (w_idx < eff) begin
          n_vec++; if (ax.wdata !== dat[w_idx]) begin n_err++; $display("FAIL %s wdata[%0d]: got %h want %h", nm, w_idx, ax.wdata, dat[w_idx]); end
          n_vec++; if (ax.wstrb !== be[w_idx]) begin n_err++; $display("FAIL %s wstrb[%0d]: got %h want %h", nm, w_idx, ax.wstrb, be[w_idx]); end
          n_vec++; if (ax.wlast !== (w_idx == eff - 1)) begin n_err++; $display("FAIL %s wlast[%0d]: got %b want %b", nm, w_idx, ax.wlast, (w_idx == eff - 1)); end
        end
        w_idx++;
        if (w_idx == eff) w_last_done = 1;
      end
      if (av.write && !av.waitrequest) av_idx++;
      if (ax.bvalid && ax.bready) b_hs_cyc = cyc;
      if (av.writeresponsevalid) begin
        wrv_cnt++;
        n_vec++; if (cyc !== b_hs_cyc + 1) begin n_err++; $display("FAIL %s wrv timing: got cycle %0d want %0d", nm, cyc, b_hs_cyc + 1); end
        n_vec++; if (av.response !== map_tab[bresp]) begin n_err++; $display("FAIL %s write response: got %b want %b", nm, av.response, map_tab[bresp]); end
      end
      if (b_hs_cyc >= 0 && cyc > b_hs_cyc + 3) break;
    end
    n_vec++; if (wrv_cnt !== 1) begin n_err++; $display("FAIL %s writeresponsevalid count: got %0d want 1", nm, wrv_cnt); end
    n_vec++; if (aw_cnt !== 1 || w_idx !== eff) begin n_err++; $display("FAIL %s aw/w counts: got %0d/%0d want 1/%0d", nm, aw_cnt, w_idx, eff); end
    idle_inputs();
  endtask

  task automatic do_read(input logic [31:0] addr, input int bc, input int early, input bit no_rlast,
                         input int rresp_sel, input string nm);
    int eff, nreal, nsend, sent, got, ar_cnt, ar_wait, ar_delay, post;
    bit read_acc, exp_err;
    logic [31:0] rd[$];
    logic [1:0]  rr[$];
    logic [31:0] exp_d[$];
    logic [1:0]  exp_r[$];
    int          hs_cyc[$];
    eff = (bc == 0) ? 1 : bc;
    nreal = (early > 0) ? early : eff;
    nsend = nreal + (no_rlast ? 1 : 0);
    exp_err = (early > 0) || no_rlast;
    sent = 0; got = 0; ar_cnt = 0; ar_wait = 0; post = 0; read_acc = 0;
    ar_delay = $urandom_range(0, 2);
    for (int i = 0; i < nsend; i++) begin
      rd.push_back($urandom);
      rr.push_back((rresp_sel < 0) ? 2'($urandom_range(0, 3)) : 2'(rresp_sel));
    end
    for (int i = 0; i < eff; i++) begin
      exp_d.push_back((i < nreal) ? rd[i] : 32'h0);
      exp_r.push_back((i < nreal) ? map_tab[rr[i]] : 2'b11);
    end
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      av.read = !read_acc; av.addr = addr; av.burstcount = BCNT_W'(bc);
      ax.arready = (ar_wait >= ar_delay);
      ax.rvalid = 0;
      if (ar_cnt > 0 && sent < nsend && $urandom_range(0, 2) != 0) begin
        ax.rvalid = 1; ax.rdata = rd[sent]; ax.rresp = rr[sent];
        ax.rlast = no_rlast ? (sent == nreal) : (sent == nreal - 1);
      end
      #1;
      if (av.read && !av.waitrequest) read_acc = 1;
      if (ax.arvalid) ar_wait++;
      if (ax.arvalid && ax.arready) begin
        ar_cnt++;
        n_vec++; if (ax.araddr !== addr) begin n_err++; $display("FAIL %s araddr: got %h want %h", nm, ax.araddr, addr); end
        n_vec++; if (ax.arlen !== 8'(eff - 1)) begin n_err++; $display("FAIL %s arlen: got %0d want %0d", nm, ax.arlen, eff - 1); end
        n_vec++; if ({ax.arsize, ax.arburst, ax.arid} !== {3'd2, 2'b01, 4'd0}) begin n_err++; $display("FAIL %s ar size/burst/id: got %b/%b/%0d want 010/01/0", nm, ax.arsize, ax.arburst, ax.arid); end
      end
      if (ax.rvalid && ax.rready) begin hs_cyc.push_back(cyc); sent++; end
      if (av.readdatavalid) begin
        got++;
        if (exp_d.size() == 0) begin
          n_vec++; n_err++; $display("FAIL %s extra read beat: got beat %0d want %0d beats", nm, got, eff);
        end else begin
          n_vec++; if (av.readdata !== exp_d[0]) begin n_err++; $display("FAIL %s readdata[%0d]: got %h want %h", nm, got - 1, av.readdata, exp_d[0]); end
          n_vec++; if (av.response !== exp_r[0]) begin n_err++; $display("FAIL %s rresp[%0d]: got %b want %b", nm, got - 1, av.response, exp_r[0]); end
          if (got <= nreal && got <= hs_cyc.size()) begin
            n_vec++; if (cyc !== hs_cyc[got - 1] + 1) begin n_err++; $display("FAIL %s rdv timing[%0d]: got cycle %0d want %0d", nm, got - 1, cyc, hs_cyc[got - 1] + 1); end
          end
          void'(exp_d.pop_front()); void'(exp_r.pop_front());
        end
      end
      if (sent == nsend) post++;
      if (post > eff + 3) break;
    end
    n_vec++; if (got !== eff || sent !== nsend) begin n_err++; $display("FAIL %s beat counts: got %0d rdv/%0d r want %0d/%0d", nm, got, sent, eff, nsend); end
    n_vec++; if (ar_cnt !== 1) begin n_err++; $display("FAIL %s ar count: got %0d want 1", nm, ar_cnt); end
    n_vec++; if (err_proto !== exp_err) begin n_err++; $display("FAIL %s err_proto: got %b want %b", nm, err_proto, exp_err); end
    idle_inputs();
    if (exp_err) begin
      @(posedge clk); #1 err_clr = 1;
      @(posedge clk); #1 err_clr = 0;
      #1;
      n_vec++; if (err_proto !== 1'b0) begin n_err++; $display("FAIL %s err_clr: got %b want 0", nm, err_proto); end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    #2 rst_n = 1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_write();
    do_write(32'h100, 1, 0, 0, 2'b00, 0, 1, 32'hDEADBEEF, "single_write");
  endtask

  task automatic test_write_burst();
    do_write(32'h400, 4, 3, 1, 2'b00, 0, 0, 32'h0, "write_burst4");
  endtask

  task automatic test_read_burst();
    do_read(32'h2000, 8, 0, 0, 1, "read_burst8");
  endtask

  task automatic test_read_short_rlast();
    do_read(32'h3000, 4, 2, 0, 0, "read_early_rlast");
  endtask

  task automatic test_read_missing_rlast();
    do_read(32'h3100, 3, 0, 1, 0, "read_no_rlast");
  endtask

  task automatic test_bc0_priority();
    do_write(32'h500, 0, 1, 0, 2'b10, 1, 0, 32'h0, "bc0_priority");
  endtask

  task automatic test_reset_mid_write();
    int beats;
    beats = 0;
    av.write = 1; av.addr = 32'h700; av.burstcount = BCNT_W'(4); av.byteenable = 4'hF;
    ax.awready = 1; ax.wready = 1;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      @(posedge clk); #1;
      av.writedata = $urandom;
      #1;
      if (ax.wvalid && ax.wready) beats++;
    end
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check_quiet("reset_mid_write");
    idle_inputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    repeat (2) @(posedge clk);
    do_read(32'h800, 1, 0, 0, 0, "read_after_reset");
  endtask

  task automatic test_random();
    int bc, eff, early;
    for (int i = 0; i < 10; i++) begin
      bc = $urandom_range(0, 12);
      eff = (bc == 0) ? 1 : bc;
      if ($urandom_range(0, 1) == 1)
        do_write({$urandom_range(0, 255), 2'b00}, bc, $urandom_range(0, 3), 2, 2'($urandom_range(0, 3)), 0, 0, 32'h0, "rand_write");
      else begin
        early = (eff >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, eff - 1) : 0;
        do_read({$urandom_range(0, 255), 2'b00}, bc, early, 0, -1, "rand_read");
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_write_burst();
    test_read_burst();
    test_read_short_rlast();
    test_read_missing_rlast();
    test_bc0_priority();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
